// File: rtl/ex_mem_latch_pkg.sv
// Shared constants for the EX/MEM pipeline register and the branch-condition evaluator.
// Flags are ordered {n,z,p,c} everywhere.
package ex_mem_latch_pkg;

    localparam int DATA_W = 16;
    localparam int CC_W   = 4;
    localparam int REG_W  = 3;

    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_P = 1;
    localparam int CC_C = 0;

    localparam logic [CC_W-1:0] BR_ALWAYS = 4'b1110;
    localparam logic [CC_W-1:0] BR_NEVER  = 4'b0000;

    // A branch fires when any flag selected by the mask is set.
    function automatic logic cc_hit(input logic [CC_W-1:0] mask,
                                    input logic [CC_W-1:0] flags);
        return |(mask & flags);
    endfunction

endpackage

// File: rtl/ex_mem_latch_cc_eval.sv
// Combinational branch-condition check: mask against flags.
// Also instantiated by the decode-stage branch predictor.
module cc_eval
    import ex_mem_latch_pkg::*;
(
    input  logic [CC_W-1:0] mask_i,
    input  logic [CC_W-1:0] flags_i,
    output logic            take_o
);

    assign take_o = cc_hit(mask_i, flags_i);

endmodule

// File: rtl/ex_mem_latch.sv
// EX->MEM pipeline register. Owns the committed nzpc flag register, resolves
// conditional branches against it, and squashes the wrong-path slot after a taken branch.
module ex_mem_latch #(
    parameter int DATA_W = ex_mem_latch_pkg::DATA_W,
    parameter int CC_W   = ex_mem_latch_pkg::CC_W,
    parameter int REG_W  = ex_mem_latch_pkg::REG_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_result,
    input  logic [CC_W-1:0]   i_ccodes,
    input  logic              i_setCc,
    input  logic              i_regWr,
    input  logic [REG_W-1:0]  i_regDst,
    input  logic              i_isBranch,
    input  logic [CC_W-1:0]   i_brCond,
    input  logic [DATA_W-1:0] i_brTarget,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_result,
    output logic              o_regWr,
    output logic [REG_W-1:0]  o_regDst,
    output logic [CC_W-1:0]   o_ccodes,
    output logic              o_brTaken,
    output logic [DATA_W-1:0] o_brTarget
);

    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] result_q,   result_d;
    logic              regwr_q,    regwr_d;
    logic [REG_W-1:0]  regdst_q,   regdst_d;
    logic [CC_W-1:0]   ccodes_q,   ccodes_d;
    logic              brtaken_q,  brtaken_d;
    logic [DATA_W-1:0] brtarget_q, brtarget_d;

    logic kill;
    logic live;
    logic cc_take;
    logic take;

    // Flags come straight from the committed register: a setter captured on the
    // previous edge is already visible, so no forwarding is needed.
    cc_eval u_cc_eval (
        .mask_i  (i_brCond),
        .flags_i (ccodes_q),
        .take_o  (cc_take)
    );

    assign kill = brtaken_q;
    assign live = i_valid & ~kill;
    assign take = live & i_isBranch & cc_take;

    always_comb begin
        valid_d    = valid_q;
        result_d   = result_q;
        regwr_d    = regwr_q;
        regdst_d   = regdst_q;
        ccodes_d   = ccodes_q;
        brtarget_d = brtarget_q;
        brtaken_d  = 1'b0;

        if (i_flush) begin
            valid_d = 1'b0;
            regwr_d = 1'b0;
        end else if (!i_stall) begin
            valid_d  = live;
            result_d = i_result;
            regdst_d = i_regDst;
            regwr_d  = i_regWr & live;
            if (live && i_setCc) begin
                ccodes_d = i_ccodes;
            end
            brtaken_d = take;
            if (take) begin
                brtarget_d = i_brTarget;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            regwr_q    <= 1'b0;
            regdst_q   <= '0;
            ccodes_q   <= '0;
            brtaken_q  <= 1'b0;
            brtarget_q <= '0;
        end else begin
            valid_q    <= valid_d;
            result_q   <= result_d;
            regwr_q    <= regwr_d;
            regdst_q   <= regdst_d;
            ccodes_q   <= ccodes_d;
            brtaken_q  <= brtaken_d;
            brtarget_q <= brtarget_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_result   = result_q;
    assign o_regWr    = regwr_q;
    assign o_regDst   = regdst_q;
    assign o_ccodes   = ccodes_q;
    assign o_brTaken  = brtaken_q;
    assign o_brTarget = brtarget_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed bench for ex_mem_latch: driver pushes hand-computed expectations,
// a monitor pops and compares one snapshot after each rising edge.
module tb_ex_mem_latch;

    localparam int W = 42;
    // Snapshot layout: {valid, result[15:0], regWr, regDst[2:0], ccodes[3:0], brTaken, brTarget[15:0]}
    localparam logic [W-1:0] M_ALL   = {W{1'b1}};
    localparam logic [W-1:0] M_NODAT = ~{1'b0, 16'hFFFF, 1'b0, 3'b111, 4'b0, 1'b0, 16'h0};

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [15:0] result_i;
    logic [3:0]  ccodes_i;
    logic        setcc_i;
    logic        regwr_i;
    logic [2:0]  regdst_i;
    logic        isbr_i;
    logic [3:0]  brcond_i;
    logic [15:0] brtgt_i;
    logic        stall_i;
    logic        flush_i;

    logic        valid_o;
    logic [15:0] result_o;
    logic        regwr_o;
    logic [2:0]  regdst_o;
    logic [3:0]  ccodes_o;
    logic        brtaken_o;
    logic [15:0] brtgt_o;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    int           tag_q[$];
    int           n_cmp;
    int           n_bad;
    int           vec_no;

    ex_mem_latch dut (
        .i_clk      (clk),
        .i_rstn     (rst_n),
        .i_valid    (valid_i),
        .i_result   (result_i),
        .i_ccodes   (ccodes_i),
        .i_setCc    (setcc_i),
        .i_regWr    (regwr_i),
        .i_regDst   (regdst_i),
        .i_isBranch (isbr_i),
        .i_brCond   (brcond_i),
        .i_brTarget (brtgt_i),
        .i_stall    (stall_i),
        .i_flush    (flush_i),
        .o_valid    (valid_o),
        .o_result   (result_o),
        .o_regWr    (regwr_o),
        .o_regDst   (regdst_o),
        .o_ccodes   (ccodes_o),
        .o_brTaken  (brtaken_o),
        .o_brTarget (brtgt_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] snap();
        return {valid_o, result_o, regwr_o, regdst_o, ccodes_o, brtaken_o, brtgt_o};
    endfunction

    // driver tasks
    task automatic set_in(input logic v, input logic [15:0] res, input logic sc,
                          input logic [3:0] cc, input logic wr, input logic [2:0] dst,
                          input logic br, input logic [3:0] cond, input logic [15:0] tgt,
                          input logic st, input logic fl);
        valid_i  = v;   result_i = res; setcc_i  = sc;   ccodes_i = cc;
        regwr_i  = wr;  regdst_i = dst; isbr_i   = br;   brcond_i = cond;
        brtgt_i  = tgt; stall_i  = st;  flush_i  = fl;
    endtask

    task automatic expect_out(input logic v, input logic [15:0] res, input logic wr,
                              input logic [2:0] dst, input logic [3:0] cc, input logic bt,
                              input logic [15:0] tgt, input logic [W-1:0] msk);
        exp_q.push_back({v, res, wr, dst, cc, bt, tgt});
        msk_q.push_back(msk);
        tag_q.push_back(vec_no);
        vec_no++;
    endtask

    task automatic check_now(input string name, input logic [W-1:0] want);
        logic [W-1:0] got;
        got = snap();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // scoreboard monitor
    initial begin
        logic [W-1:0] e, m, a;
        int t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                m = msk_q.pop_front();
                t = tag_q.pop_front();
                a = snap();
                n_cmp++;
                if (((a ^ e) & m) != '0 || $isunknown(a & m)) begin
                    n_bad++;
                    $display("FAIL vec%0d: got %h want %h (mask %h)", t, a, e, m);
                end
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        vec_no = 0;
        rst_n  = 1'b0;
        set_in(0, 16'h0, 0, 4'h0, 0, 3'd0, 0, 4'h0, 16'h0, 0, 0);
        #12;
        check_now("reset_state", '0);
        @(negedge clk);
        rst_n = 1'b1;

        // 0: ADD sets z
        @(negedge clk); set_in(1, 16'h1234, 1, 4'b0100, 1, 3'd2, 0, 4'h0,    16'h0000, 0, 0);
        expect_out(1, 16'h1234, 1, 3'd2, 4'b0100, 0, 16'h0000, M_ALL);
        // 1: branch on z, back-to-back
        @(negedge clk); set_in(1, 16'h0005, 0, 4'b0000, 0, 3'd0, 1, 4'b0100, 16'h0040, 0, 0);
        expect_out(1, 16'h0005, 0, 3'd0, 4'b0100, 1, 16'h0040, M_ALL);
        // 2: wrong-path instruction is squashed
        @(negedge clk); set_in(1, 16'h9999, 1, 4'b1000, 1, 3'd5, 0, 4'h0,    16'h0000, 0, 0);
        expect_out(0, 16'h9999, 0, 3'd5, 4'b0100, 0, 16'h0040, M_ALL);
        // 3: set p
        @(negedge clk); set_in(1, 16'h0001, 1, 4'b0010, 1, 3'd1, 0, 4'h0,    16'h0000, 0, 0);
        expect_out(1, 16'h0001, 1, 3'd1, 4'b0010, 0, 16'h0040, M_ALL);
        // 4: branch on n|z with only p set: untaken
        @(negedge clk); set_in(1, 16'h0000, 0, 4'b0000, 0, 3'd0, 1, 4'b1100, 16'h0080, 0, 0);
        expect_out(1, 16'h0000, 0, 3'd0, 4'b0010, 0, 16'h0040, M_ALL);
        // 5: never-mask
        @(negedge clk); set_in(1, 16'h0000, 0, 4'b0000, 0, 3'd0, 1, 4'b0000, 16'h00C0, 0, 0);
        expect_out(1, 16'h0000, 0, 3'd0, 4'b0010, 0, 16'h0040, M_ALL);
        // 6: always-mask, carries BEEF as its result
        @(negedge clk); set_in(1, 16'hBEEF, 0, 4'b0000, 0, 3'd3, 1, 4'b1110, 16'h0100, 0, 0);
        expect_out(1, 16'hBEEF, 0, 3'd3, 4'b0010, 1, 16'h0100, M_ALL);
        // 7-9: stall for three cycles with new inputs; pulse drops after one cycle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_in(1, 16'h1111, 1, 4'b1000, 1, 3'd5, 0, 4'h0, 16'h0000, 1, 0);
            expect_out(1, 16'hBEEF, 0, 3'd3, 4'b0010, 0, 16'h0100, M_ALL);
        end
        // 10: unstalled ADD, kill window already closed
        @(negedge clk); set_in(1, 16'h3333, 0, 4'b0000, 1, 3'd4, 0, 4'h0,    16'h0000, 0, 0);
        expect_out(1, 16'h3333, 1, 3'd4, 4'b0010, 0, 16'h0100, M_ALL);
        // 11: flush and stall together
        @(negedge clk); set_in(1, 16'h5555, 1, 4'b1111, 1, 3'd6, 0, 4'h0,    16'h0000, 1, 1);
        expect_out(0, 16'h0000, 0, 3'd0, 4'b0010, 0, 16'h0100, M_NODAT);
        // 12: taken branch on p
        @(negedge clk); set_in(1, 16'h0013, 0, 4'b0000, 0, 3'd0, 1, 4'b0010, 16'h0300, 0, 0);
        expect_out(1, 16'h0013, 0, 3'd0, 4'b0010, 1, 16'h0300, M_ALL);
        // 13: killed instruction arrives during stall: not consumed
        @(negedge clk); set_in(1, 16'h4444, 1, 4'b0001, 1, 3'd6, 0, 4'h0,    16'h0000, 1, 0);
        expect_out(1, 16'h0013, 0, 3'd0, 4'b0010, 0, 16'h0300, M_ALL);
        // 14: same instruction after stall is captured normally
        @(negedge clk); set_in(1, 16'h4444, 1, 4'b0001, 1, 3'd6, 0, 4'h0,    16'h0000, 0, 0);
        expect_out(1, 16'h4444, 1, 3'd6, 4'b0001, 0, 16'h0300, M_ALL);
        // 15: set n
        @(negedge clk); set_in(1, 16'h0AAA, 1, 4'b1000, 1, 3'd7, 0, 4'h0,    16'h0000, 0, 0);
        expect_out(1, 16'h0AAA, 1, 3'd7, 4'b1000, 0, 16'h0300, M_ALL);

        // asynchronous reset mid-cycle
        @(negedge clk);
        set_in(0, 16'h0, 0, 4'h0, 0, 3'd0, 0, 4'h0, 16'h0, 0, 0);
        check_now("pre_reset_live", {1'b1, 16'h0AAA, 1'b1, 3'd7, 4'b1000, 1'b0, 16'h0300});
        #1 rst_n = 1'b0;
        #1 check_now("async_reset", '0);
        @(negedge clk);
        rst_n = 1'b1;

        // 16: flags restart from zero after reset
        @(negedge clk); set_in(1, 16'h0BBB, 0, 4'b0000, 0, 3'd1, 0, 4'h0,    16'h0000, 0, 0);
        expect_out(1, 16'h0BBB, 0, 3'd1, 4'b0000, 0, 16'h0000, M_ALL);
        // 17: always-branch with zero flags never fires
        @(negedge clk); set_in(1, 16'h0000, 0, 4'b0000, 0, 3'd0, 1, 4'b1110, 16'h0500, 0, 0);
        expect_out(1, 16'h0000, 0, 3'd0, 4'b0000, 0, 16'h0000, M_ALL);

        @(negedge clk);
        set_in(0, 16'h0, 0, 4'h0, 0, 3'd0, 0, 4'h0, 16'h0, 0, 0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
